// File: rtl/lcd_script_sequencer.sv
// HD44780-style LCD write sequencer. Walks a 9-bit {rs, data} script from a
// synchronous-read memory and interleaves single writes from a command port.
// Each write is driven as: setup (EN low), enable pulse, hold, execution wait.
module lcd_script_sequencer #(
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned LAST_ADDR = 63,
  parameter logic [8:0]  END_CODE  = 9'h1FF,
  parameter int unsigned T_PWRUP   = 750000,
  parameter int unsigned T_SETUP   = 2,
  parameter int unsigned T_EN      = 25,
  parameter int unsigned T_HOLD    = 2,
  parameter int unsigned T_SHORT   = 2500,
  parameter int unsigned T_LONG    = 82000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [8:0]        rd_data,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rs,
  input  logic [7:0]        cmd_data,
  output logic [7:0]        DATA,
  output logic              RS,
  output logic              RW,
  output logic              EN,
  output logic              ON
);

  // Timer must hold the largest terminal count of any timed state.
  localparam int unsigned TMaxA = (T_PWRUP > T_LONG) ? T_PWRUP : T_LONG;
  localparam int unsigned TMaxB = (T_SHORT > T_EN) ? T_SHORT : T_EN;
  localparam int unsigned TMaxC = (T_SETUP > T_HOLD) ? T_SETUP : T_HOLD;
  localparam int unsigned TMaxD = (TMaxA > TMaxB) ? TMaxA : TMaxB;
  localparam int unsigned TMax  = (TMaxD > TMaxC) ? TMaxD : TMaxC;
  localparam int unsigned TW    = $clog2(TMax + 1);

  // PWRUP also spans the reset-release cycle, so its terminal count is T_PWRUP
  // rather than T_PWRUP-1; busy/ON are then visible for exactly T_PWRUP cycles.
  localparam logic [TW-1:0] PwrupEnd = TW'(T_PWRUP);
  localparam logic [TW-1:0] SetupEnd = TW'(T_SETUP - 1);
  localparam logic [TW-1:0] PulseEnd = TW'(T_EN - 1);
  localparam logic [TW-1:0] HoldEnd  = TW'(T_HOLD - 1);
  localparam logic [TW-1:0] ShortEnd = TW'(T_SHORT - 1);
  localparam logic [TW-1:0] LongEnd  = TW'(T_LONG - 1);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(LAST_ADDR);

  typedef enum logic [2:0] {
    StPwrup,
    StIdle,
    StFetch,
    StLoad,
    StSetup,
    StPulse,
    StHold,
    StWait
  } state_e;

  state_e            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]        data_q, data_d;
  logic              rs_q, rs_d;
  logic              active_q, active_d;
  logic              was_cmd_q, was_cmd_d;
  logic              done_q, done_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              en_q;
  logic              busy_q;
  logic              on_q;
  logic              start_q;

  logic              start_rise;
  logic              long_wr;
  logic [TW-1:0]     wait_end;
  logic              accept;

  assign start_rise = start & ~start_q;

  // Clear display (0x01) and return home (0x02/0x03) need the long execution time.
  assign long_wr  = ~rs_q && (data_q[7:2] == 6'd0) && (data_q != 8'd0);
  assign wait_end = long_wr ? LongEnd : ShortEnd;

  // Next-state, timer, script pointer and latched write contents.
  always_comb begin
    state_d     = state_q;
    timer_d     = '0;
    rd_addr_d   = rd_addr_q;
    data_d      = data_q;
    rs_d        = rs_q;
    active_d    = active_q;
    was_cmd_d   = was_cmd_q;
    done_d      = 1'b0;
    cmd_ready_d = 1'b0;
    accept      = 1'b0;

    unique case (state_q)
      StPwrup: begin
        if (timer_q == PwrupEnd) begin
          state_d = StIdle;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      StIdle: begin
        if (start_rise) begin
          active_d = 1'b1;
          state_d  = StFetch;
        end else if (cmd_valid) begin
          accept = 1'b1;
        end
      end

      // rd_addr is already presented; give the memory its read cycle.
      StFetch: state_d = StLoad;

      StLoad: begin
        if (rd_data == END_CODE) begin
          done_d    = 1'b1;
          rd_addr_d = '0;
          active_d  = 1'b0;
          if (cmd_valid) begin
            accept = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else begin
          data_d    = rd_data[7:0];
          rs_d      = rd_data[8];
          was_cmd_d = 1'b0;
          state_d   = StSetup;
        end
      end

      StSetup: begin
        if (timer_q == SetupEnd) begin
          state_d = StPulse;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      StPulse: begin
        if (timer_q == PulseEnd) begin
          state_d = StHold;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      StHold: begin
        if (timer_q == HoldEnd) begin
          state_d = StWait;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      StWait: begin
        if (timer_q != wait_end) begin
          timer_d = timer_q + 1'b1;
        end else if (!was_cmd_q && (rd_addr_q == LastAddr)) begin
          // Last script entry finished; a waiting command still gets its slot.
          done_d    = 1'b1;
          rd_addr_d = '0;
          active_d  = 1'b0;
          if (cmd_valid) begin
            accept = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else if (!was_cmd_q && active_q && cmd_valid) begin
          // Command slot after a script entry; pointer advances after it.
          accept = 1'b1;
        end else if (active_q) begin
          rd_addr_d = rd_addr_q + 1'b1;
          state_d   = StFetch;
        end else begin
          state_d = StIdle;
        end
      end

      default: state_d = StPwrup;
    endcase

    if (accept) begin
      cmd_ready_d = 1'b1;
      data_d      = cmd_data;
      rs_d        = cmd_rs;
      was_cmd_d   = 1'b1;
      state_d     = StSetup;
    end
  end

  // State and registered outputs; reset forces the LCD pins low immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StPwrup;
      timer_q     <= '0;
      rd_addr_q   <= '0;
      data_q      <= 8'd0;
      rs_q        <= 1'b0;
      active_q    <= 1'b0;
      was_cmd_q   <= 1'b0;
      done_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      on_q        <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      rd_addr_q   <= rd_addr_d;
      data_q      <= data_d;
      rs_q        <= rs_d;
      active_q    <= active_d;
      was_cmd_q   <= was_cmd_d;
      done_q      <= done_d;
      cmd_ready_q <= cmd_ready_d;
      en_q        <= (state_d == StPulse);
      busy_q      <= (state_d != StIdle);
      on_q        <= 1'b1;
      // Edge detector runs in every state so edges seen while busy are dropped.
      start_q     <= start;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_addr   = rd_addr_q;
  assign cmd_ready = cmd_ready_q;
  assign DATA      = data_q;
  assign RS        = rs_q;
  assign RW        = 1'b0;
  assign EN        = en_q;
  assign ON        = on_q;

endmodule

// File: tb/tb_lcd_script_sequencer.sv
// Directed bench for lcd_script_sequencer with shortened LCD timings.
module tb_lcd_script_sequencer;

  localparam int unsigned AW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_rs = 1'b0;
  logic [7:0]    cmd_data = 8'd0;
  logic          busy, done, cmd_ready, RS, RW, EN, ON;
  logic [AW-1:0] rd_addr;
  logic [8:0]    rd_data;
  logic [7:0]    DATA;

  logic [8:0]    mem [64];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Write log built by the monitor.
  int            rise_q [$];
  int            fall_q [$];
  logic [7:0]    data_log [$];
  logic          rs_log [$];
  logic [AW-1:0] addr_log [$];
  int            done_cnt, done_cyc, ready_cnt, skip_err, data_chg, on_bad;
  logic          en_prev = 1'b0;
  logic [AW-1:0] addr_prev = '0;

  logic [7:0]    t4_data [5];
  logic          t4_rs [5];

  lcd_script_sequencer #(
    .ADDR_W   (AW),
    .LAST_ADDR(7),
    .END_CODE (9'h1FF),
    .T_PWRUP  (10),
    .T_SETUP  (1),
    .T_EN     (3),
    .T_HOLD   (1),
    .T_SHORT  (5),
    .T_LONG   (20)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_rs   (cmd_rs),
    .cmd_data (cmd_data),
    .DATA     (DATA),
    .RS       (RS),
    .RW       (RW),
    .EN       (EN),
    .ON       (ON)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read script memory.
  always @(posedge clk) rd_data <= mem[rd_addr];

  // Observe LCD pins and handshakes away from the active edge.
  always @(negedge clk) begin
    if (EN && !en_prev) begin
      rise_q.push_back(cyc);
      data_log.push_back(DATA);
      rs_log.push_back(RS);
      addr_log.push_back(rd_addr);
    end
    if (!EN && en_prev) fall_q.push_back(cyc);
    if (EN && en_prev && data_log.size() > 0 && DATA != data_log[data_log.size()-1])
      data_chg++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (cmd_ready) ready_cnt++;
    if (rd_addr != addr_prev && rd_addr != addr_prev + 6'd1 && rd_addr != 6'd0) skip_err++;
    addr_prev = rd_addr;
    en_prev   = EN;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    rise_q.delete();
    fall_q.delete();
    data_log.delete();
    rs_log.delete();
    addr_log.delete();
    done_cnt  = 0;
    done_cyc  = 0;
    ready_cnt = 0;
    skip_err  = 0;
    data_chg  = 0;
    on_bad    = 0;
  endtask

  task automatic fill_end();
    for (int i = 0; i < 64; i++) mem[i] = 9'h1FF;
  endtask

  // One-cycle start pulse; returns the cycle in which it is sampled.
  task automatic pulse_start(input logic with_cmd, output int c0);
    @(negedge clk);
    start     = 1'b1;
    cmd_valid = with_cmd;
    c0        = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts busy cycles after reset release; fires a start edge mid power-up.
  task automatic count_pwrup(output int n, output bit to);
    n  = 0;
    to = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) begin
        n++;
        if (!ON) on_bad++;
      end
      start = busy && (n == 5);
      if (!busy && n > 0) begin
        to = 1'b0;
        break;
      end
    end
    start = 1'b0;
  endtask

  // Waits for done and return to idle; the requester drops cmd_valid on done.
  task automatic wait_done(input int budget, output bit to);
    bit seen = 1'b0;
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        seen      = 1'b1;
        cmd_valid = 1'b0;
      end
      if (seen && !busy) begin
        to = 1'b0;
        break;
      end
    end
    cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int n;
    int c0;
    bit to;

    fill_end();
    clear_logs();

    // 1: reset values, power-up length, start ignored during power-up
    repeat (3) @(negedge clk);
    check_eq("rst_data", DATA, 8'h00);
    check_eq("rst_ctrl", {RS, RW, EN, ON, busy, done, cmd_ready}, 7'd0);
    check_eq("rst_addr", rd_addr, 6'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    count_pwrup(n, to);
    check_eq("pwrup_timeout", to, 0);
    check_eq("pwrup_busy_cycles", n, 10);
    check_eq("pwrup_on", on_bad, 0);
    repeat (6) @(negedge clk);
    check_eq("pwrup_no_write", rise_q.size(), 0);
    check_eq("pwrup_idle", {busy, ON}, 2'b01);

    // 2: basic three-entry script
    mem[0] = 9'h038;
    mem[1] = 9'h10C;
    mem[2] = 9'h141;
    clear_logs();
    pulse_start(1'b0, c0);
    wait_done(200, to);
    repeat (3) @(negedge clk);
    check_eq("t2_timeout", to, 0);
    check_eq("t2_writes", rise_q.size(), 3);
    check_eq("t2_start_latency", rise_q[0] - c0, 4);
    check_eq("t2_w0", {rs_log[0], data_log[0]}, 9'h038);
    check_eq("t2_w1", {rs_log[1], data_log[1]}, 9'h10C);
    check_eq("t2_w2", {rs_log[2], data_log[2]}, 9'h141);
    for (int i = 0; i < 3; i++) check_eq($sformatf("t2_width%0d", i), fall_q[i] - rise_q[i], 3);
    for (int i = 0; i < 2; i++) check_eq($sformatf("t2_gap%0d", i), rise_q[i+1] - fall_q[i], 9);
    check_eq("t2_done_time", done_cyc - fall_q[2], 8);
    check_eq("t2_done_cnt", done_cnt, 1);
    check_eq("t2_addr", rd_addr, 6'd0);
    check_eq("t2_hold_data", {RS, DATA}, 9'h141);
    check_eq("t2_stable", data_chg, 0);

    // 3: clear gets the long wait, RS=1 with same byte gets the short one
    fill_end();
    mem[0] = 9'h001;
    mem[1] = 9'h101;
    clear_logs();
    pulse_start(1'b0, c0);
    wait_done(200, to);
    repeat (3) @(negedge clk);
    check_eq("t3_timeout", to, 0);
    check_eq("t3_writes", rise_q.size(), 2);
    check_eq("t3_w0", {rs_log[0], data_log[0]}, 9'h001);
    check_eq("t3_long_gap", rise_q[1] - fall_q[0], 24);
    check_eq("t3_short_done", done_cyc - fall_q[1], 8);

    // 4: command requester held active alongside the script
    fill_end();
    mem[0] = 9'h038;
    mem[1] = 9'h10C;
    t4_data = '{8'h38, 8'h80, 8'h0C, 8'h80, 8'h80};
    t4_rs   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    cmd_rs   = 1'b0;
    cmd_data = 8'h80;
    clear_logs();
    pulse_start(1'b1, c0);
    wait_done(300, to);
    repeat (3) @(negedge clk);
    check_eq("t4_timeout", to, 0);
    check_eq("t4_writes", rise_q.size(), 5);
    for (int i = 0; i < 5; i++)
      check_eq($sformatf("t4_w%0d", i), {rs_log[i], data_log[i]}, {t4_rs[i], t4_data[i]});
    check_eq("t4_ready_cnt", ready_cnt, 3);
    check_eq("t4_skip", skip_err, 0);
    check_eq("t4_addr_after_cmd", addr_log[2], 6'd1);
    check_eq("t4_gap_to_cmd", rise_q[1] - fall_q[0], 7);
    check_eq("t4_gap_to_fetch", rise_q[2] - fall_q[1], 9);
    check_eq("t4_done_cnt", done_cnt, 1);
    check_eq("t4_idle", busy, 1'b0);

    // 5: full script without terminator ends after LAST_ADDR
    fill_end();
    for (int i = 0; i < 9; i++) mem[i] = 9'h140 + 9'(i);
    clear_logs();
    pulse_start(1'b0, c0);
    wait_done(400, to);
    repeat (3) @(negedge clk);
    check_eq("t5_timeout", to, 0);
    check_eq("t5_writes", rise_q.size(), 8);
    for (int i = 0; i < 8; i++)
      check_eq($sformatf("t5_w%0d", i), {rs_log[i], data_log[i]}, 9'h140 + 9'(i));
    check_eq("t5_last_addr", addr_log[7], 6'd7);
    check_eq("t5_done_time", done_cyc - fall_q[7], 6);
    check_eq("t5_done_cnt", done_cnt, 1);
    check_eq("t5_addr", rd_addr, 6'd0);
    check_eq("t5_idle", busy, 1'b0);

    // 6: reset in the middle of an enable pulse
    fill_end();
    mem[0] = 9'h038;
    clear_logs();
    pulse_start(1'b0, c0);
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (EN) begin
        to = 1'b0;
        break;
      end
    end
    check_eq("t6_en_timeout", to, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("t6_en_async", EN, 1'b0);
    check_eq("t6_ctrl", {RS, RW, EN, ON, busy, done, cmd_ready}, 7'd0);
    check_eq("t6_data", DATA, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_logs();
    count_pwrup(n, to);
    check_eq("t6_pwrup_timeout", to, 0);
    check_eq("t6_pwrup_busy_cycles", n, 10);
    repeat (6) @(negedge clk);
    check_eq("t6_no_resume", rise_q.size(), 0);
    check_eq("t6_data_after", DATA, 8'h00);
    check_eq("t6_addr_after", rd_addr, 6'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
